// File: rtl/router_tx_pkg.sv
// Shared definitions for the router packet transmitter: FSM encoding,
// command limits and header field layout.
package router_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PARITY  = 3'd3,
      ST_GAP     = 3'd4
   } tx_state_e;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int         MAX_LEN      = 63;
   localparam int         LEN_W        = $clog2(MAX_LEN + 1);

   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                              input logic [1:0]       addr);
      logic [7:0] h;
      h = '0;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// First-word-fall-through byte FIFO holding packet payload ahead of a send
// command. The head byte is valid whenever count is non-zero.
module router_tx_buf #(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [CW-1:0] count,
   output logic          ready
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_en;
   logic          pop_en;

   // ready depends only on the registered count, so a pop cannot make room
   // for a push in the same cycle when full
   assign ready   = (count < CW'(DEPTH));
   assign push_en = push && ready;
   assign pop_en  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: sends header, buffered payload
// and parity without bubbles, then watches err through an idle gap.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for a command; rejects invalid ones
//   ST_HEADER  | header byte on pkt_data, pkt_valid high
//   ST_PAYLOAD | payload bytes streamed from the buffer head
//   ST_PARITY  | parity byte on pkt_data, pkt_valid low
//   ST_GAP     | idle gap countdown; err here sets tx_err
module router_pkt_tx
   import router_tx_pkg::*;
#(
   parameter int BUF_DEPTH  = 64,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_ready,
   output logic             cmd_rej,
   output logic [7:0]       pkt_data,
   output logic             pkt_valid,
   input  logic             busy,
   input  logic             err,
   output logic             tx_done,
   output logic             tx_err,
   output logic [6:0]       buf_count
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   tx_state_e        state, state_nx;
   logic [7:0]       data_nx;
   logic             valid_nx;
   logic [LEN_W-1:0] rem, rem_nx;
   logic [7:0]       par, par_nx;
   logic [GW-1:0]    gap_cnt, gap_nx;
   logic             rej_nx;
   logic             tx_err_nx;
   logic             pop;
   logic [7:0]       head;
   logic [CW-1:0]    cnt;
   logic             cmd_bad;
   logic [7:0]       hdr;

   router_tx_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid && s_ready),
      .wdata (s_data),
      .pop   (pop),
      .head  (head),
      .count (cnt),
      .ready (s_ready)
   );

   assign buf_count = 7'(cnt);
   assign cmd_bad   = (cmd_addr == ADDR_INVALID) || (cmd_len == '0);
   assign hdr       = make_header(cmd_len, cmd_addr);
   // a valid command waits until its whole payload is buffered, so the
   // payload phase never stalls on an empty buffer
   assign cmd_ready = (state == ST_IDLE) &&
                      (cmd_bad || (buf_count >= {1'b0, cmd_len}));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
         rem       <= '0;
         par       <= '0;
         gap_cnt   <= '0;
         cmd_rej   <= 1'b0;
         tx_err    <= 1'b0;
      end else begin
         state     <= state_nx;
         pkt_data  <= data_nx;
         pkt_valid <= valid_nx;
         rem       <= rem_nx;
         par       <= par_nx;
         gap_cnt   <= gap_nx;
         cmd_rej   <= rej_nx;
         tx_err    <= tx_err_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      data_nx   = pkt_data;
      valid_nx  = pkt_valid;
      rem_nx    = rem;
      par_nx    = par;
      gap_nx    = gap_cnt;
      rej_nx    = 1'b0;
      tx_err_nx = tx_err;
      pop       = 1'b0;
      tx_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_bad) begin
                  rej_nx = 1'b1;
               end else begin
                  data_nx   = hdr;
                  valid_nx  = 1'b1;
                  rem_nx    = cmd_len;
                  par_nx    = hdr;
                  tx_err_nx = 1'b0;
                  state_nx  = ST_HEADER;
               end
            end
         end
         ST_HEADER: begin
            if (!busy) begin
               data_nx  = head;
               pop      = 1'b1;
               state_nx = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!busy) begin
               if (rem > LEN_W'(1)) begin
                  par_nx  = par ^ pkt_data;
                  rem_nx  = rem - LEN_W'(1);
                  data_nx = head;
                  pop     = 1'b1;
               end else begin
                  data_nx  = par ^ pkt_data;
                  valid_nx = 1'b0;
                  state_nx = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (!busy) begin
               data_nx  = '0;
               gap_nx   = GW'(GAP_CYCLES);
               state_nx = ST_GAP;
            end
         end
         ST_GAP: begin
            if (err) tx_err_nx = 1'b1;
            if (gap_cnt != '0) begin
               gap_nx = gap_cnt - GW'(1);
            end else if (!busy) begin
               tx_done  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a byte-level scoreboard predicts every byte on
// pkt_data from the pushed payload and the command fields.
module tb_router_pkt_tx;

   localparam int BUF_DEPTH  = 64;
   localparam int GAP_CYCLES = 2;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_ready;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_addr = '0;
   logic [5:0] cmd_len = '0;
   logic       cmd_ready;
   logic       cmd_rej;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       busy = 1'b0;
   logic       err = 1'b0;
   logic       tx_done;
   logic       tx_err;
   logic [6:0] buf_count;

   exp_t       exp_q[$];
   logic [7:0] model_buf[$];
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   int         cnt22 = 0;
   logic [7:0] last_par = '0;

   router_pkt_tx #(.BUF_DEPTH(BUF_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .cmd_valid (cmd_valid),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_ready (cmd_ready),
      .cmd_rej   (cmd_rej),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .busy      (busy),
      .err       (err),
      .tx_done   (tx_done),
      .tx_err    (tx_err),
      .buf_count (buf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // peek while busy (byte must hold), pop on the cycle the router takes it
   always @(negedge clk) begin
      if (rst && exp_q.size() > 0) begin
         chk("pkt_data", 32'(pkt_data), 32'(exp_q[0].data));
         chk("pkt_valid", 32'(pkt_valid), 32'(exp_q[0].valid));
         if (!busy) begin
            if (!exp_q[0].valid) last_par = pkt_data;
            void'(exp_q.pop_front());
         end
      end else if (rst) begin
         chk("idle_valid", 32'(pkt_valid), 32'(0));
      end
      if (pkt_valid && pkt_data == 8'h22) cnt22++;
   end

   task automatic push_byte(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("push_ready", 32'(ok), 32'(1));
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      if (ok) model_buf.push_back(b);
   endtask

   task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len);
      logic       ok;
      logic [7:0] p;
      logic [7:0] b;
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_accept", 32'(ok), 32'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (ok && addr != 2'b11 && len != 6'd0) begin
         p = {len, addr};
         exp_q.push_back('{p, 1'b1});
         for (int i = 0; i < int'(len); i++) begin
            b = model_buf.pop_front();
            exp_q.push_back('{b, 1'b1});
            p = p ^ b;
         end
         exp_q.push_back('{p, 1'b0});
      end
   endtask

   task automatic finish_pkt(input logic inject);
      logic ok;
      int   n;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(posedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("pkt_drain", 32'(ok), 32'(1));
      #1;
      if (inject) err = 1'b1;
      n  = 0;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         n++;
         if (tx_done) begin
            ok = 1'b1;
            break;
         end
         if (inject && n == 1) begin
            @(posedge clk);
            #1;
            err = 1'b0;
         end
      end
      err = 1'b0;
      chk("done_seen", 32'(ok), 32'(1));
      chk("done_lat", 32'(n), 32'(GAP_CYCLES + 1));
      chk("tx_err_gap", 32'(tx_err), 32'(inject));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("tx_done_pulse", 32'(tx_done), 32'(0));
      chk("buf_count", 32'(buf_count), 32'(model_buf.size()));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst = 1'b0;
      #3;
      chk("rst_pkt_data", 32'(pkt_data), 32'(0));
      chk("rst_pkt_valid", 32'(pkt_valid), 32'(0));
      chk("rst_cmd_rej", 32'(cmd_rej), 32'(0));
      chk("rst_tx_done", 32'(tx_done), 32'(0));
      chk("rst_tx_err", 32'(tx_err), 32'(0));
      chk("rst_buf_count", 32'(buf_count), 32'(0));
      chk("rst_s_ready", 32'(s_ready), 32'(1));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // basic packet
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      send_cmd(2'd1, 6'd4);
      finish_pkt(1'b0);
      chk("parity1", 32'(last_par), 32'(8'h55));
      chk("buf_empty1", 32'(buf_count), 32'(0));

      // busy stall on 0x22
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      cnt22 = 0;
      send_cmd(2'd1, 6'd4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      busy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      busy = 1'b0;
      finish_pkt(1'b0);
      chk("hold22", 32'(cnt22), 32'(4));
      chk("parity2", 32'(last_par), 32'(8'h55));

      // command waits for enough payload
      push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2);
      cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd5;
      @(negedge clk);
      chk("ready_3of5", 32'(cmd_ready), 32'(0));
      @(posedge clk); #1;
      push_byte(8'hA3);
      @(negedge clk);
      chk("ready_4of5", 32'(cmd_ready), 32'(0));
      @(posedge clk); #1;
      push_byte(8'hA4);
      send_cmd(2'd0, 6'd5);
      @(negedge clk);
      chk("hdr3", 32'(pkt_data), 32'(8'h14));
      finish_pkt(1'b0);

      // invalid commands
      push_byte(8'h77);
      send_cmd(2'd3, 6'd2);
      @(negedge clk);
      chk("rej_addr", 32'(cmd_rej), 32'(1));
      chk("rej_addr_valid", 32'(pkt_valid), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rej_pulse", 32'(cmd_rej), 32'(0));
      @(posedge clk); #1;
      send_cmd(2'd0, 6'd0);
      @(negedge clk);
      chk("rej_len", 32'(cmd_rej), 32'(1));
      chk("rej_buf_count", 32'(buf_count), 32'(1));
      @(posedge clk); #1;

      // err in gap: sticky until next accept
      push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
      send_cmd(2'd2, 6'd4);
      finish_pkt(1'b1);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("tx_err_hold", 32'(tx_err), 32'(1));
      @(posedge clk); #1;
      push_byte(8'h99);
      send_cmd(2'd0, 6'd1);
      @(negedge clk);
      chk("tx_err_clr", 32'(tx_err), 32'(0));
      finish_pkt(1'b0);

      // fill buffer, then reset mid-payload
      for (int i = 0; i < BUF_DEPTH; i++) push_byte(8'(i + 1));
      @(negedge clk);
      chk("full_s_ready", 32'(s_ready), 32'(0));
      chk("full_count", 32'(buf_count), 32'(64));
      @(posedge clk); #1;
      send_cmd(2'd2, 6'd63);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      model_buf.delete();
      #1;
      chk("abort_valid", 32'(pkt_valid), 32'(0));
      chk("abort_count", 32'(buf_count), 32'(0));
      chk("abort_data", 32'(pkt_data), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 32'(pkt_valid), 32'(0));
      @(posedge clk); #1;

      // single-byte packet
      push_byte(8'h5A);
      send_cmd(2'd2, 6'd1);
      finish_pkt(1'b0);
      chk("parity_len1", 32'(last_par), 32'(8'h5C));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the router's input port: d_in byte stream, pkt_valid, honouring busy.
- Upstream pushes payload bytes into an internal buffer, then issues a command (addr, len).
- Block emits the packet: header, payload bytes, parity byte.
- Guarantees no mid-packet bubbles, then observes the router's err during an inter-packet gap.

Parameters:
- BUF_DEPTH, 64, payload buffer depth in bytes (power of 2, at least MAX_LEN).
- GAP_CYCLES, 2, minimum idle cycles after the parity byte before the next command is accepted.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte.
- s_ready  out  1  buffer can accept; push happens when s_valid && s_ready.
- cmd_valid  in  1  send-packet request.
- cmd_addr  in  2  destination port 0..2; 3 is invalid.
- cmd_len  in  6  payload length 1..63; 0 is invalid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rej  out  1  one-cycle pulse: the accepted command was invalid.
- pkt_data  out  8  drives router d_in.
- pkt_valid  out  1  drives router pkt_valid.
- busy  in  1  router busy; no transfer on an edge where busy=1.
- err  in  1  router parity error flag.
- tx_done  out  1  one-cycle pulse at end of GAP.
- tx_err  out  1  sticky; set if err seen in GAP, cleared on the next accepted command.
- buf_count  out  7  bytes held in the buffer.

Behaviour:
- Reset (async, rst=0) values:
  - state IDLE; buffer flushed.
  - pkt_data=0, pkt_valid=0, cmd_rej=0, tx_done=0, tx_err=0, buf_count=0.
  - Reset mid-packet aborts immediately; no parity byte is sent.
- Buffer:
  - First-word-fall-through FIFO.
  - s_ready = (buf_count < BUF_DEPTH), registered count only. When full, a same-cycle pop does not enable a push.
  - Push and pop in the same cycle leave the count unchanged.
- Transfer rule: a byte presented on pkt_data is consumed by the router on a rising edge with busy=0. While busy=1, pkt_data and pkt_valid hold.
- Header and parity:
  - header = {cmd_len, cmd_addr}.
  - parity = XOR of the header and all payload bytes.
- cmd_ready (combinational) = IDLE && (invalid_cmd || buf_count >= cmd_len).
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
  - IDLE, invalid accept (addr=3 or len=0): cmd_rej=1 next cycle; stay in IDLE; buffer untouched.
  - IDLE, valid accept: latch header, rem=len, par=header, clear tx_err. Next cycle pkt_data=header, pkt_valid=1, state HEADER.
  - HEADER, transfer: pkt_data<=buffer head, pop, rem stays len, state PAYLOAD.
  - PAYLOAD, transfer with rem>1: par^=pkt_data, rem-1, pkt_data<=next head, pop.
  - PAYLOAD, transfer with rem=1: pkt_data<=par^pkt_data, pkt_valid<=0, state PARITY.
  - PARITY: pkt_valid=0, parity on pkt_data. On transfer: pkt_data<=0, gap counter=GAP_CYCLES, state GAP.
  - GAP: counter decrements each cycle; err=1 on any GAP cycle sets tx_err. When counter=0 and busy=0: tx_done pulse, state IDLE.
- Latency: command accept to header on pkt_data is 1 cycle. With busy=0 throughout, the packet occupies len+2 consecutive cycles.
- pkt_valid is high for exactly len+1 transfers (header plus payload) and low during parity.
- Pushes continue during transmission.

Decomposition:
- Shared package router_tx_pkg holds:
  - state encodings;
  - ADDR_INVALID=2'b11;
  - MAX_LEN=63;
  - header field positions (len [7:2], addr [1:0]).
- One sub-module, router_tx_buf: parameterised FWFT sync FIFO exposing head, count, push, pop.

Test Plan:
1. Push 0x11,0x22,0x33,0x44; cmd addr=1 len=4, busy=0.
   -> pkt_data 0x11,0x11,0x22,0x33,0x44 with pkt_valid=1; then 0x55 with pkt_valid=0.
   -> tx_done GAP_CYCLES+1 cycles after parity; buf_count=0.
2. Same packet, busy=1 for 3 cycles while 0x22 is presented.
   -> 0x22 and pkt_valid=1 held 4 cycles; parity still 0x55; no byte lost or duplicated.
3. Push 3 bytes; cmd len=5 addr=0.
   -> cmd_ready=0 until 2 more pushes, then accept; header 0x14.
4. cmd addr=3 len=2 and cmd addr=0 len=0 -> cmd_rej pulse each; pkt_valid stays 0; buf_count unchanged.
5. Drive err=1 for one GAP cycle -> tx_err=1 held through IDLE, cleared on the next accept.
6. Push 64 bytes -> s_ready=0 at buf_count=64. Assert rst=0 mid-payload -> pkt_valid=0 and buf_count=0 immediately.
